// File: rtl/bpsk_frame_serializer.sv
`default_nettype none
// ============================================================================
// bpsk_frame_serializer : FIFO-buffered preamble/sync/payload/guard bit feeder
// for a BPSK modulator. Optional macro DIFF_ENC_EN selects DBPSK encoding.
// Rev 1.0
// ============================================================================
module bpsk_frame_serializer #(
  parameter int                    FIFO_DEPTH    = 16,
  parameter int                    PREAMBLE_BITS = 32,
  parameter int                    SYNC_WIDTH    = 16,
  parameter logic [SYNC_WIDTH-1:0] SYNC_WORD     = 16'h1ACF,
  parameter int                    GUARD_BITS    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  input  logic       sym_next,
  output logic       data_stream,
  output logic       enable,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam int c_aw   = $clog2(FIFO_DEPTH);
  localparam int c_aw1  = c_aw + 1;
  localparam int c_m1   = (PREAMBLE_BITS > SYNC_WIDTH) ? PREAMBLE_BITS : SYNC_WIDTH;
  localparam int c_m2   = (GUARD_BITS > 8) ? GUARD_BITS : 8;
  localparam int c_maxb = (c_m1 > c_m2) ? c_m1 : c_m2;
  localparam int c_cw   = $clog2(c_maxb + 1);

  localparam logic [c_cw-1:0] c_pre_last   = c_cw'(PREAMBLE_BITS - 1);
  localparam logic [c_cw-1:0] c_sync_last  = c_cw'(SYNC_WIDTH - 1);
  localparam logic [c_cw-1:0] c_byte_last  = c_cw'(7);
  localparam logic [c_cw-1:0] c_guard_last = c_cw'(GUARD_BITS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    SYNC     = 3'd2,
    PAYLOAD  = 3'd3,
    GUARD    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [c_cw-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]        sh_q, sh_d;
  logic              last_q, last_d;
  logic              data_q, data_d;
  logic              en_q, en_d;
  logic              fd_q, fd_d;
  logic              un_q, un_d;
  logic              sym_q;
  logic [c_aw-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [c_aw1-1:0]  count_q, count_d, pend_q, pend_d;
  logic [8:0]        mem_q [FIFO_DEPTH];

  logic              w_tick, w_push, w_pop, w_pend_dec, w_full, w_empty, w_prev;
  logic [8:0]        w_head;
  logic [SYNC_WIDTH-1:0] w_sync_sh;

  // The registered output doubles as the previous encoded bit e_{k-1}.
`ifdef DIFF_ENC_EN
  assign w_prev = data_q;
`else
  assign w_prev = 1'b0;
`endif

  assign w_tick  = sym_next ^ sym_q;
  assign w_full  = (count_q == c_aw1'(FIFO_DEPTH));
  assign w_empty = (count_q == '0);
  assign w_push  = s_valid & ~w_full;
  assign w_head  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + c_aw'(w_push);
    rd_ptr_d = rd_ptr_q + c_aw'(w_pop);
    count_d  = count_q + c_aw1'(w_push) - c_aw1'(w_pop);
    pend_d   = pend_q + c_aw1'(w_push & s_last) - c_aw1'(w_pend_dec);
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sh_d       = sh_q;
    last_d     = last_q;
    data_d     = data_q;
    en_d       = en_q;
    fd_d       = 1'b0;
    un_d       = un_q;
    w_pop      = 1'b0;
    w_pend_dec = 1'b0;
    w_sync_sh  = SYNC_WORD << bit_cnt_q;
    case (state_q)
      IDLE: begin
        if ((pend_q != '0) || w_full) begin
          state_d   = PREAMBLE;
          en_d      = 1'b1;
          data_d    = 1'b1;
          bit_cnt_d = '0;
        end
      end
      PREAMBLE: begin
        if (w_tick) begin
          if (bit_cnt_q == c_pre_last) begin
            state_d   = SYNC;
            bit_cnt_d = '0;
            data_d    = SYNC_WORD[SYNC_WIDTH-1] ^ w_prev;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            data_d    = bit_cnt_q[0] ^ w_prev;
          end
        end
      end
      SYNC: begin
        if (w_tick) begin
          bit_cnt_d = '0;
          if (bit_cnt_q != c_sync_last) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            data_d    = w_sync_sh[SYNC_WIDTH-2] ^ w_prev;
          end else if (!w_empty) begin
            w_pop   = 1'b1;
            sh_d    = w_head[7:0];
            last_d  = w_head[8];
            data_d  = w_head[7] ^ w_prev;
            state_d = PAYLOAD;
          end else begin
            un_d    = 1'b1;
            data_d  = 1'b0;
            state_d = GUARD;
          end
        end
      end
      PAYLOAD: begin
        if (w_tick) begin
          bit_cnt_d = '0;
          if (bit_cnt_q != c_byte_last) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            sh_d      = {sh_q[6:0], 1'b0};
            data_d    = sh_q[6] ^ w_prev;
          end else if (last_q) begin
            w_pend_dec = 1'b1;
            data_d     = 1'b0;
            state_d    = GUARD;
          end else if (!w_empty) begin
            w_pop  = 1'b1;
            sh_d   = w_head[7:0];
            last_d = w_head[8];
            data_d = w_head[7] ^ w_prev;
          end else begin
            un_d    = 1'b1;
            data_d  = 1'b0;
            state_d = GUARD;
          end
        end
      end
      GUARD: begin
        if (w_tick) begin
          if (bit_cnt_q == c_guard_last) begin
            state_d = IDLE;
            en_d    = 1'b0;
            data_d  = 1'b0;
            fd_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Payload storage carries no reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= {s_last, s_data};
  end

  always_ff @(posedge clk) begin
    sym_q <= sym_next;
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      last_q    <= 1'b0;
      data_q    <= 1'b0;
      en_q      <= 1'b0;
      fd_q      <= 1'b0;
      un_q      <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      last_q    <= last_d;
      data_q    <= data_d;
      en_q      <= en_d;
      fd_q      <= fd_d;
      un_q      <= un_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pend_q    <= pend_d;
    end
  end

  assign s_ready     = ~w_full;
  assign data_stream = data_q;
  assign enable      = en_q;
  assign busy        = (state_q != IDLE);
  assign frame_done  = fd_q;
  assign underrun    = un_q;

endmodule
`default_nettype wire

// File: tb/tb_bpsk_frame_serializer.sv
`default_nettype none
// ============================================================================
// tb_bpsk_frame_serializer : scoreboard bench for bpsk_frame_serializer
// (small-parameter instance "a" and default-parameter instance "b").
// Rev 1.0
// ============================================================================
module tb_bpsk_frame_serializer;

  localparam int PER = 8;
`ifdef DIFF_ENC_EN
  localparam bit c_diff = 1'b1;
`else
  localparam bit c_diff = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, s_valid, s_last, sel, sym_a, sym_b;
  logic [7:0] s_data;
  logic a_ready, a_data, a_en, a_busy, a_fd, a_un;
  logic b_ready, b_data, b_en, b_busy, b_fd, b_un;
  logic c_ready, c_data, c_en, c_busy, c_fd, c_un;

  bpsk_frame_serializer #(
    .FIFO_DEPTH(16), .PREAMBLE_BITS(4), .SYNC_WIDTH(8),
    .SYNC_WORD(8'hB4), .GUARD_BITS(2)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid & ~sel),
    .s_last(s_last), .s_ready(a_ready), .sym_next(sym_a),
    .data_stream(a_data), .enable(a_en), .busy(a_busy),
    .frame_done(a_fd), .underrun(a_un)
  );

  bpsk_frame_serializer dut_b (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid & sel),
    .s_last(s_last), .s_ready(b_ready), .sym_next(sym_b),
    .data_stream(b_data), .enable(b_en), .busy(b_busy),
    .frame_done(b_fd), .underrun(b_un)
  );

  always_comb begin
    c_ready = sel ? b_ready : a_ready;
    c_data  = sel ? b_data  : a_data;
    c_en    = sel ? b_en    : a_en;
    c_busy  = sel ? b_busy  : a_busy;
    c_fd    = sel ? b_fd    : a_fd;
    c_un    = sel ? b_un    : a_un;
  end

  int   total = 0;
  int   bad   = 0;
  logic exp_q[$];

  typedef struct {
    int          n;
    logic [31:0] pl;
    int          nbits;
  } vec_t;
  vec_t vt[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic enc_bit(input logic b, input logic prev);
    return b ^ (c_diff & prev);
  endfunction

  task automatic tick();
    if (sel) sym_b = ~sym_b;
    else     sym_a = ~sym_a;
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    s_data = d; s_last = l; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // Expected bit sequence for one frame, using the selected instance's framing.
  task automatic model_frame(input int n, input logic [127:0] pl);
    int          pre_n, sw, gn;
    logic [15:0] sword;
    logic [7:0]  by;
    logic        e;
    pre_n = sel ? 32 : 4;
    sw    = sel ? 16 : 8;
    sword = sel ? 16'h1ACF : 16'h00B4;
    gn    = sel ? 8 : 2;
    e     = 1'b0;
    for (int k = 0; k < pre_n; k++) begin
      e = enc_bit(~k[0], e); exp_q.push_back(e);
    end
    for (int k = sw - 1; k >= 0; k--) begin
      e = enc_bit(sword[k], e); exp_q.push_back(e);
    end
    for (int j = 0; j < n; j++) begin
      by = pl[8*(n-1-j) +: 8];
      for (int k = 7; k >= 0; k--) begin
        e = enc_bit(by[k], e); exp_q.push_back(e);
      end
    end
    for (int k = 0; k < gn; k++) exp_q.push_back(1'b0);
  endtask

  task automatic wait_enable();
    for (int i = 0; i < 20 && c_en !== 1'b1; i++) @(negedge clk);
    check("frame_start", c_en, 1);
  endtask

  task automatic run_frame(input int nbits);
    logic e;
    for (int i = 0; i < nbits; i++) begin
      repeat (PER - 1) @(negedge clk);
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_empty: bit %0d has no expectation", i);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("bit%0d {en,data}", i), {c_en, c_data}, {1'b1, e});
      end
      tick();
      @(negedge clk);
    end
  endtask

  task automatic end_frame(input logic exp_un, input logic exp_next_en);
    check("frame_done_pulse", c_fd, 1);
    check("enable_off", c_en, 0);
    check("busy_off", c_busy, 0);
    check("underrun_end", c_un, exp_un);
    @(negedge clk);
    check("frame_done_one_cycle", c_fd, 0);
    check("next_enable", c_en, exp_next_en);
  endtask

  task automatic idle_toggles(input string tag);
    for (int i = 0; i < 5; i++) begin
      tick();
      repeat (3) @(negedge clk);
      check(tag, {c_en, c_busy, c_data}, 0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] big;
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    sel = 1'b0; sym_a = 1'b0; sym_b = 1'b0;
    vt[0] = '{1, 32'h000000A5, 22};
    vt[1] = '{2, 32'h00001234, 30};
    vt[2] = '{3, 32'h0000FF3C, 38};
    vt[3] = '{4, 32'h80017EC3, 46};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_data", c_data, 0);
    check("rst_enable", c_en, 0);
    check("rst_busy", c_busy, 0);
    check("rst_frame_done", c_fd, 0);
    check("rst_underrun", c_un, 0);
    check("rst_ready", c_ready, 1);

    idle_toggles("idle_empty");
    check("idle_ready", c_ready, 1);

    for (int v = 0; v < 4; v++) begin
      for (int j = 0; j < vt[v].n; j++)
        push(vt[v].pl[8*(vt[v].n-1-j) +: 8], j == vt[v].n - 1);
      model_frame(vt[v].n, {96'b0, vt[v].pl});
      wait_enable();
      run_frame(vt[v].nbits);
      end_frame(1'b0, 1'b0);
    end

    // Two queued frames run back to back.
    push(8'h12, 1'b0); push(8'h34, 1'b1);
    push(8'h56, 1'b0); push(8'h78, 1'b1);
    model_frame(2, 128'h1234);
    model_frame(2, 128'h5678);
    wait_enable();
    run_frame(30);
    end_frame(1'b0, 1'b1);
    run_frame(30);
    end_frame(1'b0, 1'b0);

    // Reset in the middle of the payload.
    push(8'h12, 1'b0); push(8'h34, 1'b1);
    wait_enable();
    for (int i = 0; i < 15; i++) begin
      repeat (PER - 1) @(negedge clk);
      tick();
      @(negedge clk);
    end
    check("mid_payload_busy", c_busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_enable", c_en, 0);
    check("abort_busy", c_busy, 0);
    check("abort_ready", c_ready, 1);
    idle_toggles("after_abort");
    push(8'hA5, 1'b1);
    model_frame(1, 128'hA5);
    wait_enable();
    run_frame(22);
    end_frame(1'b0, 1'b0);

    // Default instance: a full FIFO without s_last starts a frame and underruns.
    sel = 1'b1;
    big = '0;
    for (int i = 0; i < 16; i++) begin
      check("fill_ready", c_ready, 1);
      big = {big[119:0], 8'(i * 37 + 11)};
      push(8'(i * 37 + 11), 1'b0);
    end
    check("full_not_ready", c_ready, 0);
    model_frame(16, big);
    wait_enable();
    run_frame(32 + 16 + 128 + 8);
    end_frame(1'b1, 1'b0);
    idle_toggles("after_underrun");
    check("underrun_sticky", c_un, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("underrun_cleared", c_un, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
